elevator_scheduler: RTL

Request scheduler for a single elevator car. It collects floor requests into a pending bitmap and selects the next destination with a SCAN (collective) policy. It dispatches that destination to the car model over a valid/ready handshake, then waits for the car's arrival report before selecting again. It sits between the floor-button request logic and the elevator car model, and is the only block that drives the car's destination.

---
 rtl/elevator_pkg.sv | 23 ++
 rtl/elevator_floor_picker.sv | 82 ++++++++
 rtl/elevator_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================
// Module   : elevator_pkg
// Brief    : Shared scheduler states, direction codes, floor count.
// Revision : 1.0
// ============================================================
package elevator_pkg;

    localparam int DEF_NUM_FLOORS = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SELECT      = 3'd1,
        DISPATCH    = 3'd2,
        WAIT_ARRIVE = 3'd3,
        FAULT       = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/elevator_floor_picker.sv
`default_nettype none
// ============================================================
// Module   : elevator_floor_picker
// Brief    : Combinational SCAN picker (nearest above / below).
// Revision : 1.0
// ============================================================
module elevator_floor_picker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  dir,
    output logic                  found,
    output logic [FLOOR_W-1:0]    pick_floor,
    output logic                  new_dir
);

    logic [NUM_FLOORS-1:0] w_above;
    logic [NUM_FLOORS-1:0] w_below;
    logic                  w_up_found;
    logic                  w_dn_found;
    logic [FLOOR_W-1:0]    w_up_floor;
    logic [FLOOR_W-1:0]    w_dn_floor;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_split
        assign w_above[i] = pending[i] && (FLOOR_W'(i) > car_floor);
        assign w_below[i] = pending[i] && (FLOOR_W'(i) < car_floor);
    end

    // Nearest above is the lowest set bit; the last hit in a descending scan wins.
    always_comb begin
        w_up_found = 1'b0;
        w_up_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (w_above[i]) begin
                w_up_found = 1'b1;
                w_up_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        w_dn_found = 1'b0;
        w_dn_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_below[i]) begin
                w_dn_found = 1'b1;
                w_dn_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found      = 1'b1;
        pick_floor = '0;
        new_dir    = dir;
        if (dir == DIR_UP) begin
            if (w_up_found) begin
                pick_floor = w_up_floor;
            end else if (w_dn_found) begin
                pick_floor = w_dn_floor;
                new_dir    = DIR_DOWN;
            end else begin
                found = 1'b0;
            end
        end else begin
            if (w_dn_found) begin
                pick_floor = w_dn_floor;
            end else if (w_up_found) begin
                pick_floor = w_up_floor;
                new_dir    = DIR_UP;
            end else begin
                found = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================
// Module   : elevator_scheduler
// Brief    : SCAN request scheduler and dispatcher for one car.
// Revision : 1.0
// ============================================================
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS     = DEF_NUM_FLOORS,
    parameter int FLOOR_W        = $clog2(NUM_FLOORS),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req_floor,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  dest_ready,
    input  logic                  arrived,
    output logic                  dest_valid,
    output logic [FLOOR_W-1:0]    dest_floor,
    output logic                  dest_up_ndown,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  queue_empty,
    output logic                  busy,
    output logic                  fault
);

    localparam int                c_wd_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_pending_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic                  r_dest_valid;
    logic                  w_dest_valid_nxt;
    logic [FLOOR_W-1:0]    r_dest_floor;
    logic [FLOOR_W-1:0]    w_dest_floor_nxt;
    logic                  r_dest_up_ndown;
    logic                  w_dest_up_ndown_nxt;
    logic                  r_fault;
    logic                  w_fault_nxt;
    logic [c_wd_w-1:0]     r_wdog;
    logic [c_wd_w-1:0]     w_wdog_nxt;

    logic [NUM_FLOORS-1:0] w_car_onehot;
    logic [NUM_FLOORS-1:0] w_req_eff;
    logic [NUM_FLOORS-1:0] w_clear_mask;
    logic                  w_found;
    logic [FLOOR_W-1:0]    w_pick_floor;
    logic                  w_new_dir;

    elevator_floor_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .pending    (r_pending),
        .car_floor  (car_floor),
        .dir        (r_dir),
        .found      (w_found),
        .pick_floor (w_pick_floor),
        .new_dir    (w_new_dir)
    );

    assign w_car_onehot = NUM_FLOORS'(1) << car_floor;
    // A car already parked at the requested floor needs no trip.
    assign w_req_eff    = (r_state == IDLE) ? (req_floor & ~w_car_onehot) : req_floor;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_pending       <= '0;
            r_dir           <= DIR_UP;
            r_dest_valid    <= 1'b0;
            r_dest_floor    <= '0;
            r_dest_up_ndown <= DIR_UP;
            r_fault         <= 1'b0;
            r_wdog          <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pending       <= w_pending_nxt;
            r_dir           <= w_dir_nxt;
            r_dest_valid    <= w_dest_valid_nxt;
            r_dest_floor    <= w_dest_floor_nxt;
            r_dest_up_ndown <= w_dest_up_ndown_nxt;
            r_fault         <= w_fault_nxt;
            r_wdog          <= w_wdog_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_dir_nxt           = r_dir;
        w_dest_valid_nxt    = r_dest_valid;
        w_dest_floor_nxt    = r_dest_floor;
        w_dest_up_ndown_nxt = r_dest_up_ndown;
        w_fault_nxt         = r_fault;
        w_wdog_nxt          = r_wdog;
        w_clear_mask        = '0;

        case (r_state)
            IDLE: begin
                if (r_pending != '0) begin
                    w_state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (w_found) begin
                    w_dest_floor_nxt    = w_pick_floor;
                    w_dest_up_ndown_nxt = w_new_dir;
                    w_dir_nxt           = w_new_dir;
                    w_dest_valid_nxt    = 1'b1;
                    w_state_nxt         = DISPATCH;
                end else begin
                    w_clear_mask = w_car_onehot;
                    w_state_nxt  = IDLE;
                end
            end
            DISPATCH: begin
                if (r_dest_valid && dest_ready) begin
                    w_dest_valid_nxt = 1'b0;
                    w_wdog_nxt       = '0;
                    w_state_nxt      = WAIT_ARRIVE;
                end
            end
            WAIT_ARRIVE: begin
                if (arrived) begin
                    w_clear_mask = w_car_onehot;
                    w_state_nxt  = SELECT;
                end else if (r_wdog == c_wd_last) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = FAULT;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            FAULT: begin
                w_dest_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Clear is applied after the OR so it wins over a same-cycle request.
        if (r_state == FAULT) begin
            w_pending_nxt = r_pending;
        end else begin
            w_pending_nxt = (r_pending | w_req_eff) & ~w_clear_mask;
        end
    end

    assign dest_valid    = r_dest_valid;
    assign dest_floor    = r_dest_floor;
    assign dest_up_ndown = r_dest_up_ndown;
    assign pending       = r_pending;
    assign fault         = r_fault;
    assign queue_empty   = (r_pending == '0);
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire
